carset_cmd_arbiter: RTL

// - Single owner of the car-set user settings (volume, mp3 mode, sun mode, focus) shared by two requesters:
//   the decoded bluetooth byte (bt_cmd) and the on-board panel buttons (pnl_cmd).
// - Qualifies each source's command by hold time, arbitrates, applies one command, then enforces a cooldown.
// - Replaces separate per-source debounce/rate-limit paths with one sequenced, deterministic update point.

---
 rtl/carset_cmd_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/carset_cmd_arbiter.sv
// carset_cmd_arbiter: single update point for car-set settings shared by bluetooth and panel sources.
// Each source's code must be held HOLD samples before it requests. One winner is applied per
// APPLY cycle, followed by COOLDOWN cycles during which no command is taken.
// Ports: clk_i clock; rst_ni sync active-low reset; bt_cmd_i / pnl_cmd_i command codes;
//   vol_dis_i / mp3mode_dis_i mark up/down resp. mp3 codes invalid; volum_o, mp3_mode_o, sun_mode_o,
//   focus_o settings; cmd_ack_o one-cycle APPLY pulse; grant_src_o owner of last command ([0]=bt, [1]=panel).
// Option: define CARSET_RR_ARB_EN for round-robin tie-breaking (default fixed priority bt > panel).
module carset_cmd_arbiter #(
    parameter int HOLD     = 10,
    parameter int COOLDOWN = 300000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] bt_cmd_i,
    input  logic [7:0] pnl_cmd_i,
    input  logic       vol_dis_i,
    input  logic       mp3mode_dis_i,
    output logic [1:0] volum_o,
    output logic       mp3_mode_o,
    output logic [1:0] sun_mode_o,
    output logic       focus_o,
    output logic       cmd_ack_o,
    output logic [1:0] grant_src_o
);
    localparam int HW = $clog2(HOLD + 1);
    localparam int CW = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {IDLE, APPLY, COOL} state_e;

    state_e        state_q;
    logic [7:0]    bt_prev_q, pnl_prev_q, code_q;
    logic [HW-1:0] bt_cnt_q, bt_cnt_d, pnl_cnt_q, pnl_cnt_d;
    logic [CW-1:0] cd_q;
    logic [1:0]    volum_q, sun_q, grant_q;
    logic          mp3_q, focus_q, ack_q;
    logic          bt_req, pnl_req, pick_pnl;

    function automatic logic code_ok(input logic [7:0] c, input logic vd, input logic md);
        return (c == 8'h01 || c == 8'h02) ? !vd :
               (c == 8'h08)               ? !md :
               (c == 8'h04 || c == 8'h40);
    endfunction

    always_comb begin
        bt_req    = bt_cnt_q == HW'(HOLD);
        pnl_req   = pnl_cnt_q == HW'(HOLD);
        bt_cnt_d  = !code_ok(bt_cmd_i, vol_dis_i, mp3mode_dis_i) ? '0 :
                    (bt_cmd_i != bt_prev_q) ? HW'(1) :
                    bt_req ? bt_cnt_q : bt_cnt_q + HW'(1);
        pnl_cnt_d = !code_ok(pnl_cmd_i, vol_dis_i, mp3mode_dis_i) ? '0 :
                    (pnl_cmd_i != pnl_prev_q) ? HW'(1) :
                    pnl_req ? pnl_cnt_q : pnl_cnt_q + HW'(1);
`ifdef CARSET_RR_ARB_EN
        // on a tie the source that did not own the last command wins; 00 after reset favours bt
        pick_pnl  = pnl_req && (!bt_req || grant_q == 2'b01);
`else
        pick_pnl  = pnl_req && !bt_req;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            bt_prev_q  <= '0;
            pnl_prev_q <= '0;
            bt_cnt_q   <= '0;
            pnl_cnt_q  <= '0;
            code_q     <= '0;
            cd_q       <= '0;
            volum_q    <= 2'd0;
            mp3_q      <= 1'b1;
            sun_q      <= 2'd0;
            focus_q    <= 1'b0;
            ack_q      <= 1'b0;
            grant_q    <= 2'b00;
        end else begin
            bt_prev_q  <= bt_cmd_i;
            pnl_prev_q <= pnl_cmd_i;
            bt_cnt_q   <= bt_cnt_d;
            pnl_cnt_q  <= pnl_cnt_d;
            ack_q      <= 1'b0;
            case (state_q)
                IDLE: if (bt_req || pnl_req) begin
                    // the qualified code is the previous sample; the live input may already have moved on
                    code_q  <= pick_pnl ? pnl_prev_q : bt_prev_q;
                    grant_q <= pick_pnl ? 2'b10 : 2'b01;
                    ack_q   <= 1'b1;
                    state_q <= APPLY;
                end
                APPLY: begin
                    volum_q <= code_q == 8'h01 ? (volum_q == 2'd3 ? volum_q : volum_q + 2'd1) :
                               code_q == 8'h02 ? (volum_q == 2'd0 ? volum_q : volum_q - 2'd1) : volum_q;
                    sun_q   <= code_q == 8'h04 ? (sun_q == 2'd2 ? 2'd0 : sun_q + 2'd1) : sun_q;
                    mp3_q   <= mp3_q ^ (code_q == 8'h08);
                    focus_q <= focus_q ^ (code_q == 8'h40);
                    cd_q    <= CW'(COOLDOWN);
                    state_q <= COOL;
                end
                COOL: begin
                    cd_q <= cd_q - CW'(1);
                    if (cd_q == CW'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign volum_o     = volum_q;
    assign mp3_mode_o  = mp3_q;
    assign sun_mode_o  = sun_q;
    assign focus_o     = focus_q;
    assign cmd_ack_o   = ack_q;
    assign grant_src_o = grant_q;
endmodule
